// File: rtl/nx_ctrl_rx_framer.sv
// Host-side ingress framer for nx_control: packs host bytes MSB-first into request words,
// buffers completed words in a small FIFO and drops partial words that stall mid-frame.
module nx_ctrl_rx_framer #(
  parameter int REQ_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [REQ_WIDTH-1:0] inbound_data_o,
  output logic                 inbound_valid_o,
  input  logic                 inbound_ready_i,
  output logic                 status_err_o,
  output logic [7:0]           err_count_o
);

  localparam int BYTES = (REQ_WIDTH + 7) / 8;
  localparam int AW    = 8 * BYTES;
  // The final byte of a word is never stored, so the register holds BYTES-1 bytes.
  localparam int ARW   = (BYTES > 1) ? 8 * (BYTES - 1) : 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int NW    = PW + 1;
  localparam int IW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);
  localparam logic [IW-1:0] TIMEOUT_V = IW'(TIMEOUT);

  logic [CW-1:0]        byte_cnt_r;
  logic [ARW-1:0]       asm_r;
  logic [IW-1:0]        idle_r;
  logic [REQ_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [NW-1:0]        count_r;
  logic                 ready_r;
  logic                 valid_r;
  logic [REQ_WIDTH-1:0] data_r;
  logic                 err_r;
  logic [7:0]           err_cnt_r;

  logic                 accept_s;
  logic                 last_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 fire_s;
  logic [AW-1:0]        word_full_s;
  logic [ARW-1:0]       asm_shift_s;
  logic [REQ_WIDTH-1:0] word_s;

  logic [CW-1:0]        byte_cnt_n;
  logic [ARW-1:0]       asm_n;
  logic [IW-1:0]        idle_n;
  logic [PW-1:0]        wr_ptr_n;
  logic [PW-1:0]        rd_ptr_n;
  logic [NW-1:0]        count_n;
  logic                 full_n;
  logic                 ready_n;
  logic [REQ_WIDTH-1:0] head_n;

  assign rx_ready_o      = ready_r & ~rst_i;
  assign inbound_data_o  = data_r;
  assign inbound_valid_o = valid_r;
  assign status_err_o    = err_r;
  assign err_count_o     = err_cnt_r;

  assign accept_s = rx_valid_i & rx_ready_o;
  assign last_s   = (byte_cnt_r == LAST_BYTE);
  assign push_s   = accept_s & last_s;
  assign pop_s    = valid_r & inbound_ready_i;
  // Excess upper bits of the first byte fall off here when REQ_WIDTH is not byte aligned.
  assign word_s   = word_full_s[REQ_WIDTH-1:0];

  generate
    if (BYTES > 1) begin : g_multi
      assign word_full_s = {asm_r, rx_data_i};
      assign asm_shift_s = word_full_s[ARW-1:0];
    end else begin : g_single
      assign word_full_s = rx_data_i;
      assign asm_shift_s = asm_r;
    end

    if (TIMEOUT > 0) begin : g_wd
      assign fire_s = ~accept_s & (byte_cnt_r != '0) & (idle_r == TIMEOUT_V);
    end else begin : g_no_wd
      assign fire_s = 1'b0;
    end
  endgenerate

  // Byte assembly and watchdog next state; an accept always takes priority over a timeout.
  always_comb begin
    byte_cnt_n = byte_cnt_r;
    asm_n      = asm_r;
    idle_n     = idle_r;
    if (accept_s) begin
      idle_n = '0;
      if (last_s) begin
        byte_cnt_n = '0;
        asm_n      = '0;
      end else begin
        byte_cnt_n = byte_cnt_r + CW'(1);
        asm_n      = asm_shift_s;
      end
    end else if (fire_s) begin
      byte_cnt_n = '0;
      asm_n      = '0;
      idle_n     = '0;
    end else if (byte_cnt_r != '0) begin
      idle_n = idle_r + IW'(1);
    end else begin
      idle_n = '0;
    end
  end

  // FIFO pointer/occupancy next state and the head word presented after this edge.
  always_comb begin
    wr_ptr_n = push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
    rd_ptr_n = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_n = count_r + NW'(1);
      2'b01:   count_n = count_r - NW'(1);
      default: count_n = count_r;
    endcase
    full_n  = (count_n == FULL_CNT);
    ready_n = ~((byte_cnt_n == LAST_BYTE) & full_n);
    // A word pushed into the slot that becomes the head must bypass the storage array.
    if (push_s && (wr_ptr_r == rd_ptr_n)) begin
      head_n = word_s;
    end else begin
      head_n = mem_r[rd_ptr_n];
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt_r <= '0;
      asm_r      <= '0;
      idle_r     <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      data_r     <= '0;
      err_r      <= 1'b0;
      err_cnt_r  <= 8'h00;
    end else begin
      byte_cnt_r <= byte_cnt_n;
      asm_r      <= asm_n;
      idle_r     <= idle_n;
      wr_ptr_r   <= wr_ptr_n;
      rd_ptr_r   <= rd_ptr_n;
      count_r    <= count_n;
      ready_r    <= ready_n;
      valid_r    <= (count_n != '0);
      data_r     <= head_n;
      err_r      <= fire_s;
      if (fire_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  // Word storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

endmodule

// File: tb/tb_nx_ctrl_rx_framer.sv
// Bench for nx_ctrl_rx_framer: two configurations driven by shared stimulus, each checked
// every cycle against a queue-level reference model, plus directed scenario checks.
module tb_nx_ctrl_rx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        in_ready;

  logic        rdy0, val0, err0;
  logic [31:0] data0;
  logic [7:0]  cnt0;
  logic        rdy1, val1, err1;
  logic [19:0] data1;
  logic [7:0]  cnt1;

  nx_ctrl_rx_framer #(.REQ_WIDTH(32), .FIFO_DEPTH(2), .TIMEOUT(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rdy0), .inbound_data_o(data0), .inbound_valid_o(val0),
    .inbound_ready_i(in_ready), .status_err_o(err0), .err_count_o(cnt0));

  nx_ctrl_rx_framer #(.REQ_WIDTH(20), .FIFO_DEPTH(4), .TIMEOUT(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rdy1), .inbound_data_o(data1), .inbound_valid_o(val1),
    .inbound_ready_i(in_ready), .status_err_o(err1), .err_count_o(cnt1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: per lane, bytes gathered so far, a circular word queue, idle run, errors.
  int          m_bytes [2] = '{4, 3};
  int          m_depth [2] = '{2, 4};
  int          m_to    [2] = '{4, 0};
  logic [31:0] m_mask  [2] = '{32'hFFFF_FFFF, 32'h000F_FFFF};
  int          nb [2];
  logic [31:0] acc [2];
  logic [31:0] fq [2][4];
  int          fh [2];
  int          fc [2];
  int          idle [2];
  int          errs [2];
  bit          pulse [2];
  bit          took [2];

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      nb[l] = 0; acc[l] = 32'h0; fh[l] = 0; fc[l] = 0;
      idle[l] = 0; errs[l] = 0; pulse[l] = 1'b0; took[l] = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic cyc(input bit v, input logic [7:0] d, input bit ir, input bit r);
    logic [31:0] o_rdy [2];
    logic [31:0] o_val [2];
    logic [31:0] o_dat [2];
    logic [31:0] o_err [2];
    logic [31:0] o_cnt [2];
    bit mrdy, a, pop;
    @(negedge clk);
    rst_i = r; rx_valid = v; rx_data = d; in_ready = ir;
    #1;
    o_rdy[0] = 32'(rdy0); o_val[0] = 32'(val0); o_dat[0] = data0;
    o_err[0] = 32'(err0); o_cnt[0] = 32'(cnt0);
    o_rdy[1] = 32'(rdy1); o_val[1] = 32'(val1); o_dat[1] = 32'(data1);
    o_err[1] = 32'(err1); o_cnt[1] = 32'(cnt1);
    for (int l = 0; l < 2; l++) begin
      mrdy = !r && !((nb[l] == m_bytes[l] - 1) && (fc[l] == m_depth[l]));
      check_eq($sformatf("L%0d rx_ready", l), o_rdy[l], 32'(mrdy));
      check_eq($sformatf("L%0d inbound_valid", l), o_val[l], 32'(fc[l] != 0));
      if (fc[l] != 0) check_eq($sformatf("L%0d inbound_data", l), o_dat[l], fq[l][fh[l]]);
      check_eq($sformatf("L%0d status_err", l), o_err[l], 32'(pulse[l]));
      check_eq($sformatf("L%0d err_count", l), o_cnt[l], 32'(errs[l]));
      took[l] = 1'b0;
      if (r) begin
        nb[l] = 0; acc[l] = 32'h0; fh[l] = 0; fc[l] = 0; idle[l] = 0; errs[l] = 0; pulse[l] = 1'b0;
      end else begin
        pulse[l] = 1'b0;
        a   = v && mrdy;
        pop = (fc[l] != 0) && ir;
        took[l] = a;
        if (pop) begin
          fh[l] = (fh[l] + 1) % m_depth[l];
          fc[l]--;
        end
        if (a) begin
          acc[l] = (acc[l] << 8) | {24'h0, d};
          nb[l]++;
          idle[l] = 0;
          if (nb[l] == m_bytes[l]) begin
            fq[l][(fh[l] + fc[l]) % m_depth[l]] = acc[l] & m_mask[l];
            fc[l]++;
            nb[l] = 0;
            acc[l] = 32'h0;
          end
        end else if (nb[l] != 0) begin
          if (m_to[l] != 0 && idle[l] == m_to[l]) begin
            nb[l] = 0; acc[l] = 32'h0; idle[l] = 0; pulse[l] = 1'b1;
            if (errs[l] < 255) errs[l]++;
          end else begin
            idle[l]++;
          end
        end else begin
          idle[l] = 0;
        end
      end
    end
  endtask

  // Offer one byte until the 32-bit lane takes it, with a bounded number of attempts.
  task automatic send(input logic [7:0] b, input bit ir);
    int k;
    k = 0;
    do begin
      cyc(1'b1, b, ir, 1'b0);
      k++;
    end while (!took[0] && k < 40);
    check_eq("send_accepted", 32'(took[0]), 32'h1);
  endtask

  initial begin
    rst_i = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; in_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Basic word assembly and single-cycle presentation.
    send(8'hDE, 1'b1); send(8'hAD, 1'b1); send(8'hBE, 1'b1); send(8'hEF, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("deadbeef_valid", 32'(val0), 32'h1);
    check_eq("deadbeef_data", data0, 32'hDEAD_BEEF);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("deadbeef_once", 32'(val0), 32'h0);

    // Backpressure: FIFO full refuses the last byte until one cycle after the first pop.
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) send(((i % 4) == 3) ? 8'((i / 4) + 1) : 8'h00, 1'b0);
    cyc(1'b1, 8'h03, 1'b0, 1'b0);
    check_eq("full_stall", 32'(rdy0), 32'h0);
    repeat (2) cyc(1'b1, 8'h03, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b1, 1'b0);
    check_eq("pop1_data", data0, 32'h1);
    check_eq("still_stalled", 32'(rdy0), 32'h0);
    cyc(1'b1, 8'h03, 1'b1, 1'b0);
    check_eq("pop2_data", data0, 32'h2);
    check_eq("stall_release", 32'(rdy0), 32'h1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("pop3_data", data0, 32'h3);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Watchdog discards a stalled partial word.
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    repeat (6) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("wd_pulse", 32'(err0), 32'h1);
    check_eq("wd_count", 32'(cnt0), 32'h1);
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("wd_clean_word", data0, 32'h0102_0304);

    // A short idle gap must not trip the watchdog.
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h33, 1'b1); send(8'h44, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("gap_word", data0, 32'h1122_3344);
    check_eq("gap_no_err", 32'(cnt0), 32'h1);

    // Non byte-aligned width drops the top of the first byte.
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    send(8'hF1, 1'b1); send(8'h23, 1'b1); send(8'h45, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("w20_valid", 32'(val1), 32'h1);
    check_eq("w20_data", 32'(data1), 32'h0001_2345);

    // Reset with a buffered word and a partial word drops everything silently.
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    send(8'h05, 1'b0); send(8'h06, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("rst_valid", 32'(val0), 32'h0);
    check_eq("rst_errcnt", 32'(cnt0), 32'h0);
    check_eq("rst_ready", 32'(rdy0), 32'h1);
    send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'hCC, 1'b1); send(8'hDD, 1'b1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("post_rst_word", data0, 32'hAABB_CCDD);

    // Random traffic with segments of sparse, moderate and saturated byte rates.
    for (int seg = 0; seg < 30; seg++) begin
      int pv;
      pv = ((seg % 3) == 0) ? 2 : (((seg % 3) == 1) ? 7 : 10);
      for (int i = 0; i < 100; i++) begin
        logic [7:0] rb;
        rb = 8'($urandom);
        cyc(($urandom_range(0, 9) < pv), rb, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 499) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
